pixel_scanout_ctrl: RTL and testbench

PIXEL_SCANOUT_CTRL -- requirements
Module: pixel_scanout_ctrl

---
 rtl/scanout_pkg.sv | 22 ++
 rtl/pixel_fifo.sv | 64 ++++++
 rtl/pixel_scanout_ctrl.sv | 153 +++++++++++++++
 tb/tb_pixel_scanout_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scanout_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scanout_pkg: shared FSM state type and address helpers for the scanout.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package scanout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } scanout_state_t;

    localparam int BYTES_PER_PIXEL = 4;

    // Framebuffer addresses wrap modulo 2^32.
    function automatic logic [31:0] next_pixel_addr(input logic [31:0] addr);
        return addr + 32'(BYTES_PER_PIXEL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_fifo: first-word fall-through buffer, power-of-two depth.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pixel_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full buffer is still safe when a pop frees a slot this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_scanout_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_scanout_ctrl: fetches one framebuffer per frame and streams pixels.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pixel_scanout_ctrl
    import scanout_pkg::*;
#(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [31:0] fb_base0_i,
    input  logic [31:0] fb_base1_i,
    input  logic        frame_idx_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_data_i,
    output logic        pixel_valid_o,
    input  logic        pixel_ready_i,
    output logic [23:0] pixel_data_o,
    output logic        frame_done_o,
    output logic        busy_o
);

    localparam int TOTAL = H_RES * V_RES;
    localparam int REQ_W = $clog2(TOTAL + 1);
    localparam int PIX_W = $clog2(TOTAL);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    scanout_state_t state;
    scanout_state_t next_state;

    logic [31:0]    req_addr;
    logic [REQ_W-1:0] req_count;
    logic [PIX_W-1:0] pix_count;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  fifo_count;
    logic [CW:0]    inflight;
    logic           fifo_full;
    logic           fifo_empty;
    logic [23:0]    fifo_head;
    logic           frame_done;
    logic           start_frame;
    logic           req_valid;
    logic           req_fire;
    logic           last_req;
    logic           rsp_accept;
    logic           pix_pop;
    logic           last_pix;
    logic           unused_rsp_bits;

    assign unused_rsp_bits = ^mem_rsp_data_i[31:24];

    // Requests are throttled so every response in flight has a guaranteed slot.
    assign inflight    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign req_valid   = (state == ST_FETCH) && !fifo_full && (inflight < (CW+1)'(FIFO_DEPTH));
    assign req_fire    = req_valid && mem_req_ready_i;
    assign last_req    = (req_count == REQ_W'(TOTAL - 1));
    assign rsp_accept  = mem_rsp_valid_i && (outstanding != '0);
    assign pix_pop     = !fifo_empty && pixel_ready_i;
    assign last_pix    = (pix_count == PIX_W'(TOTAL - 1));
    assign start_frame = (state == ST_IDLE) && enable_i;

    assign mem_req_valid_o = req_valid;
    assign mem_req_addr_o  = req_addr;
    assign pixel_valid_o   = !fifo_empty;
    assign pixel_data_o    = fifo_head;
    assign frame_done_o    = frame_done;
    assign busy_o          = (state != ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (enable_i) begin
                    next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (req_fire && last_req) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (frame_done) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_addr    <= '0;
            req_count   <= '0;
            outstanding <= '0;
            pix_count   <= '0;
            frame_done  <= 1'b0;
        end else begin
            // Base is captured only here, so mid-frame base/index changes wait a frame.
            if (start_frame) begin
                req_addr  <= frame_idx_i ? fb_base1_i : fb_base0_i;
                req_count <= '0;
            end else if (req_fire) begin
                req_addr  <= next_pixel_addr(req_addr);
                req_count <= req_count + REQ_W'(1);
            end

            case ({req_fire, rsp_accept})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            if (pix_pop) begin
                pix_count <= last_pix ? '0 : pix_count + PIX_W'(1);
            end
            frame_done <= pix_pop && last_pix;
        end
    end

    pixel_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_pixel_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (rsp_accept),
        .push_data (mem_rsp_data_i[23:0]),
        .pop       (pix_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_pixel_scanout_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pixel_scanout_ctrl: randomized bench with a frame-level memory model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pixel_scanout_ctrl;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int DEPTH = 4;
    localparam int TOTAL = H * V;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic [31:0] fb_base0_i = 32'h1000;
    logic [31:0] fb_base1_i = 32'h2000;
    logic        frame_idx_i = 1'b1;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        pixel_valid_o;
    logic        pixel_ready_i;
    logic [23:0] pixel_data_o;
    logic        frame_done_o;
    logic        busy_o;

    pixel_scanout_ctrl #(
        .H_RES      (H),
        .V_RES      (V),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .enable_i        (enable_i),
        .fb_base0_i      (fb_base0_i),
        .fb_base1_i      (fb_base1_i),
        .frame_idx_i     (frame_idx_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .pixel_valid_o   (pixel_valid_o),
        .pixel_ready_i   (pixel_ready_i),
        .pixel_data_o    (pixel_data_o),
        .frame_done_o    (frame_done_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory contents: random table mixed with the address so every word differs.
    logic [23:0] tbl [256];
    function automatic logic [23:0] mem_word(input logic [31:0] a);
        return tbl[a[9:2]] ^ a[23:0];
    endfunction

    typedef struct {
        logic [31:0] addr;
        longint      due;
    } rsp_t;
    rsp_t   rq[$];
    longint cyc = 0;
    int     lat = 1;
    int     rdy_mode = 1;
    int     prdy_mode = 1;

    function automatic logic pick(input int mode);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return (mode != 0);
    endfunction

    // Memory and handshake driver: responses come lat cycles after the request.
    initial begin
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        mem_req_ready_i = 1'b0;
        pixel_ready_i   = 1'b0;
        forever begin
            @(posedge clk_i);
            cyc++;
            #1;
            mem_req_ready_i = pick(rdy_mode);
            pixel_ready_i   = pick(prdy_mode);
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                mem_rsp_valid_i = 1'b1;
                mem_rsp_data_i  = {8'($urandom), mem_word(rq[0].addr)};
                void'(rq.pop_front());
            end else begin
                mem_rsp_valid_i = 1'b0;
                mem_rsp_data_i  = $urandom;
            end
        end
    end

    // Reference model of the frame: requests walk base+4*i, pixels pop in that order.
    bit          m_active = 0;
    bit          m_done = 0;
    int          m_reqn = 0;
    int          m_pix = 0;
    int          m_out = 0;
    int          m_fifo = 0;
    int          m_frames = 0;
    logic [31:0] m_base = '0;
    bit          xfer, pop_ev, acc, start, done_next;
    bit          exp_rv;
    rsp_t        ent;

    always @(negedge clk_i) begin
        xfer   = mem_req_valid_o && mem_req_ready_i;
        pop_ev = pixel_valid_o && pixel_ready_i;
        acc    = mem_rsp_valid_i && (m_out > 0);
        exp_rv = m_active && (m_reqn < TOTAL) && (m_out + m_fifo < DEPTH);

        check("busy", busy_o, m_active);
        check("req_valid", mem_req_valid_o, exp_rv);
        check("pix_valid", pixel_valid_o, m_fifo != 0);
        check("frame_done", frame_done_o, m_done);
        if (xfer) begin
            check("req_addr", mem_req_addr_o, m_base + 32'(4 * m_reqn));
            ent.addr = mem_req_addr_o;
            ent.due  = cyc + lat;
            rq.push_back(ent);
        end
        if (pop_ev) begin
            check("pix_data", pixel_data_o, mem_word(m_base + 32'(4 * m_pix)));
        end

        if (rst_i) begin
            m_active = 0;
            m_done   = 0;
            m_reqn   = 0;
            m_pix    = 0;
            m_out    = 0;
            m_fifo   = 0;
        end else begin
            start = !m_active && enable_i;
            if (xfer) m_reqn++;
            m_out  = m_out + int'(xfer) - int'(acc);
            m_fifo = m_fifo + int'(acc) - int'(pop_ev);
            if (acc) check("fifo_room", m_fifo <= DEPTH, 1);
            done_next = pop_ev && (m_pix == TOTAL - 1);
            if (pop_ev) m_pix = (m_pix + 1) % TOTAL;
            if (m_done) m_active = 0;
            if (start) begin
                m_active = 1;
                m_base   = frame_idx_i ? fb_base1_i : fb_base0_i;
                m_reqn   = 0;
            end
            m_done = done_next;
            if (done_next) m_frames++;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int n = 0;
        while (m_frames < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, m_frames >= target, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        enable_i = 1'b0;
        while (m_active && n < 300) begin
            tick();
            n++;
        end
        tick();
        check(tag, busy_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) tbl[i] = 24'($urandom);
        repeat (3) tick();
        check("rst_busy", busy_o, 0);
        check("rst_req_valid", mem_req_valid_o, 0);
        check("rst_pix_valid", pixel_valid_o, 0);
        check("rst_frame_done", frame_done_o, 0);
        check("rst_addr", mem_req_addr_o, 0);
        check("rst_pix_data", pixel_data_o, 0);
        rst_i = 1'b0;
        tick();

        // Back-to-back frames from base1 with an ideal memory.
        lat = 1; rdy_mode = 1; prdy_mode = 1;
        enable_i = 1'b1;
        wait_frames(m_frames + 2, 200, "s1_frames");
        wait_idle("s1_idle");

        // Display stalled: only the buffer's worth of requests may issue.
        prdy_mode = 0;
        enable_i = 1'b1;
        tick();
        enable_i = 1'b0;
        repeat (20) tick();
        check("s2_req_count", m_reqn, 4);
        check("s2_req_valid", mem_req_valid_o, 0);
        check("s2_pix_valid", pixel_valid_o, 1);
        prdy_mode = 1;
        wait_frames(m_frames + 1, 200, "s2_frames");
        wait_idle("s2_idle");

        // Latency 3 with random handshakes on both sides.
        lat = 3; rdy_mode = 2; prdy_mode = 2;
        enable_i = 1'b1;
        wait_frames(m_frames + 2, 800, "s3_frames");
        wait_idle("s3_idle");

        // Enable dropped mid-frame: the frame still completes.
        lat = 1; rdy_mode = 1; prdy_mode = 2;
        enable_i = 1'b1;
        n = 0;
        while (!(m_active && m_pix == 2) && n < 200) begin tick(); n++; end
        check("s4_reach_pix2", m_pix, 2);
        enable_i = 1'b0;
        wait_frames(m_frames + 1, 200, "s4_frames");
        wait_idle("s4_idle");
        repeat (3) tick();
        check("s4_stays_idle", busy_o, 0);

        // Reset mid-fetch with two requests left in the memory pipeline.
        lat = 3; rdy_mode = 1; prdy_mode = 1;
        enable_i = 1'b1;
        n = 0;
        while (!(m_active && m_out == 1) && n < 50) begin tick(); n++; end
        check("s5_reach_out1", m_out, 1);
        enable_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("s5_busy", busy_o, 0);
        check("s5_req_valid", mem_req_valid_o, 0);
        check("s5_pix_valid", pixel_valid_o, 0);
        check("s5_frame_done", frame_done_o, 0);
        check("s5_addr", mem_req_addr_o, 0);
        check("s5_pix_data", pixel_data_o, 0);
        repeat (6) tick();
        check("s5_late_dropped", pixel_valid_o, 0);
        enable_i = 1'b1;
        wait_frames(m_frames + 1, 200, "s5_frames");
        wait_idle("s5_idle");

        // Frame index and base changed mid-frame take effect next frame only.
        lat = 1; rdy_mode = 2; prdy_mode = 1;
        frame_idx_i = 1'b0;
        enable_i = 1'b1;
        n = 0;
        while (!(m_active && m_pix == 3) && n < 200) begin tick(); n++; end
        check("s6_base_old", m_base, 32'h1000);
        frame_idx_i = 1'b1;
        fb_base0_i  = 32'h3000;
        wait_frames(m_frames + 2, 400, "s6_frames");
        check("s6_base_new", m_base, 32'h2000);
        wait_idle("s6_idle");

        // Address wrap at the top of the 32-bit space.
        lat = int'($urandom_range(1, 3)); rdy_mode = 2; prdy_mode = 2;
        fb_base0_i  = 32'hFFFF_FFF0;
        frame_idx_i = 1'b0;
        enable_i = 1'b1;
        wait_frames(m_frames + 1, 400, "s7_frames");
        wait_idle("s7_idle");
        check("s7_end_addr", mem_req_addr_o, 32'h0000_0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
